rs_alu_issue: RTL and testbench
===============================

Name: rs_alu_issue

Overview:
- ALU reservation station sitting directly upstream of the physical register file (PRF).
- Buffers renamed ALU micro-ops from dispatch and tracks source readiness from writeback broadcasts.
- Selects the oldest ready entry, drives the PRF ALU read port, and delivers the op payload to the ALU aligned with the PRF's registered read data.

Parameters:
DEPTH, 8, number of entries (power of two, 2..16)
TAG_W, 7, physical register tag width (128 physical regs)
ROB_W, 5, ROB index width
OP_W, 4, ALU opcode width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
flush  in  1  synchronous: drops every entry and the issue pipeline register
disp_valid  in  1  dispatch op valid
disp_ready  out  1  accepts dispatch; = !full, from registered state only
disp_op  in  OP_W  ALU opcode
disp_imm  in  32  immediate
disp_use_imm  in  1  src2 is immediate; ps2 treated ready
disp_pd  in  TAG_W  destination tag
disp_ps1 / disp_ps2  in  TAG_W  source tags
disp_ps1_rdy / disp_ps2_rdy  in  1  source ready per rename busy table
disp_rob  in  ROB_W  ROB index
wb_alu_en / wb_alu_pd  in  1 / TAG_W  ALU writeback broadcast (same signals as PRF write port)
wb_mem_en / wb_mem_pd  in  1 / TAG_W  memory writeback broadcast
fu_ready  in  1  ALU can accept an op next cycle
read_en_alu  out  1  PRF ALU read enable
ps1_alu / ps2_alu  out  TAG_W  PRF read tags
ex_valid  out  1  payload valid; coincides with PRF ps1/ps2_out_alu
ex_op / ex_imm / ex_use_imm / ex_pd / ex_rob  out  -  registered payload for the ALU

Behaviour:
- Reset (reset=0, async): all entry valid bits 0; age matrix 0; every output 0 except disp_ready=1.
- Entry fields: valid, op, imm, use_imm, pd, ps1, r1, ps2, r2, rob.
- Dispatch fires on disp_valid && disp_ready.
  - Write to the lowest-index free entry.
  - r1 = disp_ps1_rdy | (ps1==0) | same-cycle broadcast match on ps1; same rule for r2, plus use_imm forces r2=1.
- Wakeup: each cycle, any valid entry with a source tag equal to an enabled wb_*_pd sets the matching r bit. Both ports may match in the same cycle. Tag 0 never matches.
- Ready bits are registered. An entry woken in cycle N is eligible no earlier than cycle N+1, because the PRF write lands at the same edge the read samples and the PRF returns old data on a same-cycle read/write.
- Select (combinational, from registered state): eligible = valid && r1 && r2. Oldest eligible entry wins, by age matrix.
  - Age matrix: row i bit j=1 means i is older than j.
  - On dispatch into slot k: row k cleared; column k set for all valid entries.
- Issue fires when any entry is eligible && fu_ready && !flush.
  - In cycle N: read_en_alu=1, ps1_alu/ps2_alu = winner's tags; the winner's valid clears at the edge.
  - Otherwise read_en_alu=0; tags hold their last value.
- Pipeline: payload is registered at the issue edge. In cycle N+1, ex_valid=1 and ex_* hold the payload, matching PRF data in the same cycle. Issue-to-execute latency is 1 cycle.
- Throughput: at most 1 issue and 1 dispatch per cycle.
- Full with simultaneous issue: disp_ready stays 0 that cycle; the freed slot is usable next cycle.
- Dispatch and issue in the same cycle: a newly dispatched entry is not eligible until the next cycle.
- flush: all valid bits clear and ex_valid=0 next cycle. Dispatch and issue in the flush cycle are discarded. Flush has priority over everything except reset.
- Reset mid-operation: immediate clear regardless of state.

Optional Feature:
- Macro RS_OCCUPANCY_EN.
- Defined: adds output occupancy [$clog2(DEPTH):0], a registered count of valid entries.
  - +1 on dispatch, -1 on issue, net 0 when both occur.
  - 0 on reset and on flush.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package ooo_pkg: TAG_W, ROB_W, OP_W constants; typedef rs_entry_t (packed entry fields); typedef alu_op_e (opcode enum).
- Sub-module rs_age_select: takes the age matrix and eligible vector; produces one-hot grant and a grant_valid flag. Purely combinational.
- Entry storage, wakeup, and the issue pipeline register stay in the top module.

Test Plan:
- Reset, then dispatch op with ps1=5, ps2=6 both ready, fu_ready=1 → cycle+1: read_en_alu=1, ps1_alu=5, ps2_alu=6; cycle+2: ex_valid=1, ex_pd and ex_rob equal the dispatched values.
- Dispatch with ps1=9 not ready; pulse wb_mem_en with pd=9 in cycle N → read_en_alu first asserts in N+1, never in N.
- Dispatch A then B, both waiting on tag 12; broadcast 12 via wb_alu → A issues before B, on consecutive cycles.
- Fill all 8 entries (disp_ready→0), then issue one → disp_ready=1 the following cycle, not the same cycle; the 9th dispatch lands in the freed slot.
- Same-cycle dispatch with disp_ps2=20 (not ready) and wb_alu_pd=20 → the entry issues the next cycle, not deadlocked.
- flush with 3 valid entries and ex_valid=1 → next cycle: no valid entries, ex_valid=0, disp_ready=1; with RS_OCCUPANCY_EN, occupancy=0.

Source files
------------

// File: rtl/ooo_pkg.sv
// ooo_pkg: shared widths, ALU opcode enum, reservation-station entry layout
// and the writeback tag-match helper.
package ooo_pkg;
  localparam int TAG_W = 7;
  localparam int ROB_W = 5;
  localparam int OP_W  = 4;
  typedef enum logic [OP_W-1:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
    ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI
  } alu_op_e;
  typedef struct packed {
    logic             valid;
    alu_op_e          op;
    logic [31:0]      imm;
    logic             use_imm;
    logic [TAG_W-1:0] pd;
    logic [TAG_W-1:0] ps1;
    logic             r1;
    logic [TAG_W-1:0] ps2;
    logic             r2;
    logic [ROB_W-1:0] rob;
  } rs_entry_t;
  // Tag 0 is the hardwired-ready register and never matches a broadcast
  function automatic logic wb_hit(input logic [TAG_W-1:0] t, input logic ae,
                                  input logic [TAG_W-1:0] ap, input logic me,
                                  input logic [TAG_W-1:0] mp);
    return (t != '0) && ((ae && ap == t) || (me && mp == t));
  endfunction
endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: one-hot grant of the oldest eligible entry from an age matrix
// (row i bit j set means entry i is older than entry j).
module rs_age_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0] age [DEPTH],
  input  logic [DEPTH-1:0] elig,
  output logic [DEPTH-1:0] grant,
  output logic             grant_valid
);
  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = elig[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && elig[j] && age[j][i]) grant[i] = 1'b0;
    end
  end
  assign grant_valid = |elig;
endmodule

// File: rtl/rs_alu_issue.sv
// rs_alu_issue: ALU reservation station driving the PRF ALU read port.
// Optional RS_OCCUPANCY_EN adds a registered occupancy count output.
module rs_alu_issue
  import ooo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [31:0]      disp_imm,
  input  logic             disp_use_imm,
  input  logic [TAG_W-1:0] disp_pd,
  input  logic [TAG_W-1:0] disp_ps1,
  input  logic [TAG_W-1:0] disp_ps2,
  input  logic             disp_ps1_rdy,
  input  logic             disp_ps2_rdy,
  input  logic [ROB_W-1:0] disp_rob,
  input  logic             wb_alu_en,
  input  logic [TAG_W-1:0] wb_alu_pd,
  input  logic             wb_mem_en,
  input  logic [TAG_W-1:0] wb_mem_pd,
  input  logic             fu_ready,
  output logic             read_en_alu,
  output logic [TAG_W-1:0] ps1_alu,
  output logic [TAG_W-1:0] ps2_alu,
  output logic             ex_valid,
  output logic [OP_W-1:0]  ex_op,
  output logic [31:0]      ex_imm,
  output logic             ex_use_imm,
  output logic [TAG_W-1:0] ex_pd,
  output logic [ROB_W-1:0] ex_rob
`ifdef RS_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH):0] occupancy
`endif
);
  localparam int IW = $clog2(DEPTH);
  rs_entry_t        ent [DEPTH];
  logic [DEPTH-1:0] age [DEPTH];
  logic [DEPTH-1:0] valid, elig, grant;
  logic             grant_valid, issue, fire;
  logic [IW-1:0]    sel, slot;
  logic [TAG_W-1:0] last_ps1, last_ps2;
  rs_entry_t        win, new_ent;
  function automatic logic hit(input logic [TAG_W-1:0] t);
    return wb_hit(t, wb_alu_en, wb_alu_pd, wb_mem_en, wb_mem_pd);
  endfunction
  always_comb begin
    valid = '0;
    elig  = '0;
    slot  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      valid[i] = ent[i].valid;
      elig[i]  = ent[i].valid && ent[i].r1 && ent[i].r2;
      if (!ent[i].valid) slot = IW'(i);
    end
  end
  rs_age_select #(.DEPTH(DEPTH)) u_sel (
    .age         (age),
    .elig        (elig),
    .grant       (grant),
    .grant_valid (grant_valid)
  );
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++)
      if (grant[i]) sel = IW'(i);
  end
  assign win         = ent[sel];
  assign disp_ready  = ~&valid;
  assign issue       = grant_valid && fu_ready && !flush;
  assign fire        = disp_valid && disp_ready && !flush;
  assign read_en_alu = issue;
  assign ps1_alu     = issue ? win.ps1 : last_ps1;
  assign ps2_alu     = issue ? win.ps2 : last_ps2;
  // Same-cycle broadcasts are folded into the ready bits captured at dispatch
  assign new_ent = '{
    valid:   1'b1,
    op:      alu_op_e'(disp_op),
    imm:     disp_imm,
    use_imm: disp_use_imm,
    pd:      disp_pd,
    ps1:     disp_ps1,
    r1:      disp_ps1_rdy || disp_ps1 == '0 || hit(disp_ps1),
    ps2:     disp_ps2,
    r2:      disp_ps2_rdy || disp_use_imm || disp_ps2 == '0 || hit(disp_ps2),
    rob:     disp_rob
  };
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
        age[i] <= '0;
      end
      last_ps1   <= '0;
      last_ps2   <= '0;
      ex_valid   <= 1'b0;
      ex_op      <= '0;
      ex_imm     <= '0;
      ex_use_imm <= 1'b0;
      ex_pd      <= '0;
      ex_rob     <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].valid <= 1'b0;
        age[i]       <= '0;
      end
      ex_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (hit(ent[i].ps1)) ent[i].r1 <= 1'b1;
        if (hit(ent[i].ps2)) ent[i].r2 <= 1'b1;
        if (fire) age[i][slot] <= valid[i];
      end
      if (issue) begin
        ent[sel].valid <= 1'b0;
        last_ps1       <= win.ps1;
        last_ps2       <= win.ps2;
        ex_op          <= win.op;
        ex_imm         <= win.imm;
        ex_use_imm     <= win.use_imm;
        ex_pd          <= win.pd;
        ex_rob         <= win.rob;
      end
      if (fire) begin
        ent[slot] <= new_ent;
        age[slot] <= '0;
      end
      ex_valid <= issue;
    end
  end
`ifdef RS_OCCUPANCY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occupancy <= '0;
    else if (flush) occupancy <= '0;
    else occupancy <= occupancy + ($clog2(DEPTH)+1)'(fire) - ($clog2(DEPTH)+1)'(issue);
  end
`endif
endmodule

// File: tb/tb_rs_alu_issue.sv
// tb_rs_alu_issue: directed self-checking bench for rs_alu_issue (DEPTH=8).
module tb_rs_alu_issue;
  import ooo_pkg::*;
  logic             clk = 1'b0;
  logic             reset, flush, disp_valid, disp_ready, disp_use_imm;
  logic [OP_W-1:0]  disp_op, ex_op;
  logic [31:0]      disp_imm, ex_imm;
  logic [TAG_W-1:0] disp_pd, disp_ps1, disp_ps2, wb_alu_pd, wb_mem_pd;
  logic             disp_ps1_rdy, disp_ps2_rdy, wb_alu_en, wb_mem_en, fu_ready;
  logic [ROB_W-1:0] disp_rob, ex_rob;
  logic             read_en_alu, ex_valid, ex_use_imm;
  logic [TAG_W-1:0] ps1_alu, ps2_alu, ex_pd;
`ifdef RS_OCCUPANCY_EN
  logic [3:0]       occupancy;
`endif
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  rs_alu_issue #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_imm(disp_imm), .disp_use_imm(disp_use_imm), .disp_pd(disp_pd),
    .disp_ps1(disp_ps1), .disp_ps2(disp_ps2), .disp_ps1_rdy(disp_ps1_rdy),
    .disp_ps2_rdy(disp_ps2_rdy), .disp_rob(disp_rob),
    .wb_alu_en(wb_alu_en), .wb_alu_pd(wb_alu_pd),
    .wb_mem_en(wb_mem_en), .wb_mem_pd(wb_mem_pd),
    .fu_ready(fu_ready), .read_en_alu(read_en_alu),
    .ps1_alu(ps1_alu), .ps2_alu(ps2_alu),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_imm(ex_imm),
    .ex_use_imm(ex_use_imm), .ex_pd(ex_pd), .ex_rob(ex_rob)
`ifdef RS_OCCUPANCY_EN
    , .occupancy(occupancy)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_disp(input logic [TAG_W-1:0] ps1, input logic r1,
                          input logic [TAG_W-1:0] ps2, input logic r2,
                          input logic [TAG_W-1:0] pd, input logic [ROB_W-1:0] rob,
                          input logic ui, input logic [31:0] imm);
    disp_valid = 1'b1;
    disp_ps1 = ps1; disp_ps1_rdy = r1;
    disp_ps2 = ps2; disp_ps2_rdy = r2;
    disp_pd = pd; disp_rob = rob; disp_use_imm = ui; disp_imm = imm;
  endtask
  initial begin
    reset = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_op = '0; disp_imm = '0;
    disp_use_imm = 1'b0; disp_pd = '0; disp_ps1 = '0; disp_ps2 = '0;
    disp_ps1_rdy = 1'b0; disp_ps2_rdy = 1'b0; disp_rob = '0;
    wb_alu_en = 1'b0; wb_alu_pd = '0; wb_mem_en = 1'b0; wb_mem_pd = '0; fu_ready = 1'b1;
    tick(); tick();
    chk("rst_disp_ready", 64'(disp_ready), 64'(1));
    chk("rst_read_en", 64'(read_en_alu), 64'(0));
    chk("rst_ex_valid", 64'(ex_valid), 64'(0));
    chk("rst_ps1_alu", 64'(ps1_alu), 64'(0));
    chk("rst_ex_pd", 64'(ex_pd), 64'(0));
    reset = 1'b1;
    // basic issue: both sources ready
    disp_op = 4'd1;
    set_disp(7'd5, 1'b1, 7'd6, 1'b1, 7'd33, 5'd7, 1'b0, 32'd0);
    tick(); disp_valid = 1'b0;
    chk("t1_read_en", 64'(read_en_alu), 64'(1));
    chk("t1_ps1", 64'(ps1_alu), 64'(5));
    chk("t1_ps2", 64'(ps2_alu), 64'(6));
    tick();
    chk("t1_ex_valid", 64'(ex_valid), 64'(1));
    chk("t1_ex_pd", 64'(ex_pd), 64'(33));
    chk("t1_ex_rob", 64'(ex_rob), 64'(7));
    chk("t1_ex_op", 64'(ex_op), 64'(1));
    chk("t1_read_en_off", 64'(read_en_alu), 64'(0));
    chk("t1_ps1_hold", 64'(ps1_alu), 64'(5));
    // wakeup via mem broadcast is visible one cycle later
    disp_op = 4'd2;
    set_disp(7'd9, 1'b0, 7'd0, 1'b0, 7'd40, 5'd1, 1'b0, 32'd0);
    tick(); disp_valid = 1'b0;
    chk("t2_wait", 64'(read_en_alu), 64'(0));
    wb_mem_en = 1'b1; wb_mem_pd = 7'd9; #1;
    chk("t2_not_same_cycle", 64'(read_en_alu), 64'(0));
    tick(); wb_mem_en = 1'b0;
    chk("t2_read_en", 64'(read_en_alu), 64'(1));
    chk("t2_ps1", 64'(ps1_alu), 64'(9));
    tick();
    chk("t2_ex_pd", 64'(ex_pd), 64'(40));
    // age order: A in slot 1 is older than B later placed in slot 0
    set_disp(7'd77, 1'b0, 7'd0, 1'b0, 7'd60, 5'd4, 1'b0, 32'd0);
    tick();
    set_disp(7'd12, 1'b0, 7'd0, 1'b0, 7'd50, 5'd2, 1'b1, 32'h1234);
    tick(); disp_valid = 1'b0;
    wb_mem_en = 1'b1; wb_mem_pd = 7'd77;
    tick(); wb_mem_en = 1'b0;
    chk("t3_x_issue", 64'(ps1_alu), 64'(77));
    tick();
    chk("t3_x_ex_pd", 64'(ex_pd), 64'(60));
    set_disp(7'd3, 1'b1, 7'd12, 1'b0, 7'd51, 5'd3, 1'b0, 32'd0);
    tick(); disp_valid = 1'b0;
    chk("t3_both_wait", 64'(read_en_alu), 64'(0));
    wb_alu_en = 1'b1; wb_alu_pd = 7'd12;
    tick(); wb_alu_en = 1'b0;
    chk("t3_a_read_en", 64'(read_en_alu), 64'(1));
    chk("t3_a_ps1", 64'(ps1_alu), 64'(12));
    chk("t3_a_ps2", 64'(ps2_alu), 64'(0));
    tick();
    chk("t3_a_ex_pd", 64'(ex_pd), 64'(50));
    chk("t3_a_ex_imm", 64'(ex_imm), 64'(32'h1234));
    chk("t3_a_ex_use_imm", 64'(ex_use_imm), 64'(1));
    chk("t3_b_read_en", 64'(read_en_alu), 64'(1));
    chk("t3_b_ps1", 64'(ps1_alu), 64'(3));
    chk("t3_b_ps2", 64'(ps2_alu), 64'(12));
    tick();
    chk("t3_b_ex_pd", 64'(ex_pd), 64'(51));
    chk("t3_idle", 64'(read_en_alu), 64'(0));
    // fill all eight entries, each waiting on tag 100+i
    for (int i = 0; i < 8; i++) begin
      set_disp(7'(100 + i), 1'b0, 7'd0, 1'b0, 7'(70 + i), 5'(i), 1'b0, 32'd0);
      tick();
    end
    disp_valid = 1'b0;
    chk("t4_full", 64'(disp_ready), 64'(0));
`ifdef RS_OCCUPANCY_EN
    chk("t4_occupancy", 64'(occupancy), 64'(8));
`endif
    wb_alu_en = 1'b1; wb_alu_pd = 7'd103;
    tick(); wb_alu_en = 1'b0;
    chk("t4_issue", 64'(read_en_alu), 64'(1));
    chk("t4_issue_ps1", 64'(ps1_alu), 64'(103));
    chk("t4_full_during_issue", 64'(disp_ready), 64'(0));
    set_disp(7'd8, 1'b1, 7'd0, 1'b0, 7'd90, 5'd9, 1'b0, 32'd0);
    tick();
    chk("t4_ready_after", 64'(disp_ready), 64'(1));
    chk("t4_ex_pd", 64'(ex_pd), 64'(73));
    tick(); disp_valid = 1'b0;
    chk("t4_refull", 64'(disp_ready), 64'(0));
    chk("t4_ninth_issue", 64'(read_en_alu), 64'(1));
    chk("t4_ninth_ps1", 64'(ps1_alu), 64'(8));
    tick();
    chk("t4_ninth_ex_pd", 64'(ex_pd), 64'(90));
    // same-cycle dispatch and broadcast on ps2
    set_disp(7'd21, 1'b1, 7'd20, 1'b0, 7'd91, 5'd10, 1'b0, 32'd0);
    wb_alu_en = 1'b1; wb_alu_pd = 7'd20;
    tick(); disp_valid = 1'b0; wb_alu_en = 1'b0;
    chk("t5_read_en", 64'(read_en_alu), 64'(1));
    chk("t5_ps2", 64'(ps2_alu), 64'(20));
    wb_mem_en = 1'b1; wb_mem_pd = 7'd100;
    tick(); wb_mem_en = 1'b0;
    chk("t5_ex_valid", 64'(ex_valid), 64'(1));
    chk("t5_ex_pd", 64'(ex_pd), 64'(91));
    // flush with live entries, an eligible entry and a pending dispatch
    flush = 1'b1;
    set_disp(7'd22, 1'b1, 7'd0, 1'b0, 7'd92, 5'd11, 1'b0, 32'd0);
    #1;
    chk("t6_no_issue_on_flush", 64'(read_en_alu), 64'(0));
    tick(); flush = 1'b0; disp_valid = 1'b0;
    chk("t6_ex_valid", 64'(ex_valid), 64'(0));
    chk("t6_disp_ready", 64'(disp_ready), 64'(1));
    chk("t6_read_en", 64'(read_en_alu), 64'(0));
    chk("t6_ps1_hold", 64'(ps1_alu), 64'(21));
`ifdef RS_OCCUPANCY_EN
    chk("t6_occupancy", 64'(occupancy), 64'(0));
`endif
    wb_alu_en = 1'b1; wb_alu_pd = 7'd101;
    tick(); wb_alu_en = 1'b0;
    chk("t6_entries_gone", 64'(read_en_alu), 64'(0));
    // asynchronous reset mid-operation
    set_disp(7'd4, 1'b1, 7'd0, 1'b0, 7'd93, 5'd12, 1'b0, 32'd0);
    tick(); disp_valid = 1'b0;
    chk("t7_read_en", 64'(read_en_alu), 64'(1));
    tick();
    chk("t7_ex_valid", 64'(ex_valid), 64'(1));
    #2 reset = 1'b0;
    #1;
    chk("t7_async_ex_valid", 64'(ex_valid), 64'(0));
    chk("t7_async_ps1", 64'(ps1_alu), 64'(0));
    chk("t7_async_ex_pd", 64'(ex_pd), 64'(0));
    chk("t7_async_disp_ready", 64'(disp_ready), 64'(1));
    tick();
    reset = 1'b1;
    tick();
    chk("t7_after_reset_idle", 64'(read_en_alu), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
